// File: rtl/bist_session_ctrl_pkg.sv
// Shared definitions for the BIST session controller: FSM state encodings
// and the default MISR signature width.
package bist_session_ctrl_pkg;

   localparam int SIG_W_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_RUN     = 3'd2,
      S_FLUSH   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } bist_state_e;

endpackage

// File: rtl/bist_session_ctrl_edge_det.sv
// Registered rising-edge detector. The history flop has a configurable reset
// value so a level already high when reset releases is not seen as an edge.
module bist_edge_det #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev;

   // History flop: remembers last cycle's input level.
   always_ff @(posedge clk) begin
      if (reset) prev <= RST_VAL;
      else       prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/bist_session_ctrl.sv
// Session-level BIST sequencer: on a bist_start rising edge it initialises the
// LFSR and MISR, applies N_PATTERNS patterns, lets the CUT pipeline drain into
// the MISR for PIPE_LAT cycles, then checks the signature against GOLDEN_SIG.
module bist_session_ctrl
   import bist_session_ctrl_pkg::*;
#(
   parameter int               N_PATTERNS = 100,
   parameter int               PIPE_LAT   = 1,
   parameter int               SIG_W      = SIG_W_DEF,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = '0,
   parameter int               CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bist_start,
   input  logic [SIG_W-1:0] signature,
   output logic             lfsr_rst,
   output logic             lfsr_en,
   output logic             misr_rst,
   output logic             misr_en,
   output logic             running,
   output logic             bist_end,
   output logic             pass_nfail
);

   // Terminal counts; the flush value is unused when there is no CUT latency.
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = (PIPE_LAT > 0) ? CNT_W'(PIPE_LAT - 1) : '0;

   bist_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             start_edge;

   // History resets high so a start held through reset needs a fresh 0->1.
   bist_edge_det #(.RST_VAL(1'b1)) u_start_edge (
      .clk   (clk),
      .reset (reset),
      .din   (bist_start),
      .rise  (start_edge)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and Moore output decode.
   always_comb begin
      state_nxt = state;
      lfsr_rst  = 1'b0;
      lfsr_en   = 1'b0;
      misr_rst  = 1'b0;
      misr_en   = 1'b0;
      running   = 1'b0;
      bist_end  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_edge) state_nxt = S_INIT;
         end
         S_INIT: begin
            lfsr_rst  = 1'b1;
            misr_rst  = 1'b1;
            running   = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            lfsr_en = 1'b1;
            misr_en = 1'b1;
            running = 1'b1;
            if (cnt == RUN_LAST) state_nxt = (PIPE_LAT > 0) ? S_FLUSH : S_COMPARE;
         end
         S_FLUSH: begin
            misr_en = 1'b1;
            running = 1'b1;
            if (cnt == FLUSH_LAST) state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            running   = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            bist_end  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pattern / flush counter; restarts from zero at each phase boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         case (state)
            S_RUN:   cnt <= (cnt == RUN_LAST)   ? '0 : cnt + CNT_W'(1);
            S_FLUSH: cnt <= (cnt == FLUSH_LAST) ? '0 : cnt + CNT_W'(1);
            default: cnt <= '0;
         endcase
      end
   end

   // Verdict register: cleared at session start, loaded at compare, held after.
   always_ff @(posedge clk) begin
      if (reset)                   pass_nfail <= 1'b0;
      else if (state == S_INIT)    pass_nfail <= 1'b0;
      else if (state == S_COMPARE) pass_nfail <= (signature == GOLDEN_SIG);
   end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Directed bench for bist_session_ctrl: one PIPE_LAT=1 instance and one
// PIPE_LAT=0 instance, both N_PATTERNS=8, GOLDEN_SIG=16'hBEEF.
module tb_bist_session_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic [15:0] sig;

   logic lfsr_rst_a, lfsr_en_a, misr_rst_a, misr_en_a, running_a, bist_end_a, pass_a;
   logic lfsr_rst_b, lfsr_en_b, misr_rst_b, misr_en_b, running_b, bist_end_b, pass_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bist_session_ctrl #(
      .N_PATTERNS(8), .PIPE_LAT(1), .SIG_W(16), .GOLDEN_SIG(16'hBEEF), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .bist_start(start_a), .signature(sig),
      .lfsr_rst(lfsr_rst_a), .lfsr_en(lfsr_en_a), .misr_rst(misr_rst_a),
      .misr_en(misr_en_a), .running(running_a), .bist_end(bist_end_a),
      .pass_nfail(pass_a)
   );

   bist_session_ctrl #(
      .N_PATTERNS(8), .PIPE_LAT(0), .SIG_W(16), .GOLDEN_SIG(16'hBEEF), .CNT_W(8)
   ) dut_nolat (
      .clk(clk), .reset(reset), .bist_start(start_b), .signature(sig),
      .lfsr_rst(lfsr_rst_b), .lfsr_en(lfsr_en_b), .misr_rst(misr_rst_b),
      .misr_en(misr_en_b), .running(running_b), .bist_end(bist_end_b),
      .pass_nfail(pass_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observed signals of the selected instance, packed as
   // {lfsr_rst, lfsr_en, misr_rst, misr_en, running, bist_end, pass_nfail}.
   function automatic logic [6:0] obs(input bit sel);
      if (sel) return {lfsr_rst_b, lfsr_en_b, misr_rst_b, misr_en_b, running_b, bist_end_b, pass_b};
      return {lfsr_rst_a, lfsr_en_a, misr_rst_a, misr_en_a, running_a, bist_end_a, pass_a};
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Raise start just before edge t, then watch cycles t+1..t+ncyc.
   // toggle_at: drop start after cycle k and raise again after k+1 (0 = off).
   // reset_at : assert reset after cycle k, check all-zero at k+1 (0 = off).
   task automatic session(input bit sel, input int ncyc, input int toggle_at,
                          input int reset_at, output int rst_k, output int rst_cnt,
                          output int lfsr_cnt, output int misr_cnt, output int run_cnt,
                          output int end_k, output int end_cnt, output int pn_k1,
                          output int pn_k2, output int zero_ok);
      logic [6:0] o;
      rst_k = 0; rst_cnt = 0; lfsr_cnt = 0; misr_cnt = 0; run_cnt = 0;
      end_k = 0; end_cnt = 0; pn_k1 = -1; pn_k2 = -1; zero_ok = -1;
      set_start(sel, 1'b1);
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         o = obs(sel);
         if (o[6] && o[4]) begin
            rst_cnt++;
            if (rst_k == 0) rst_k = k;
         end
         if (o[5]) lfsr_cnt++;
         if (o[3]) misr_cnt++;
         if (o[2]) run_cnt++;
         if (o[1]) begin
            end_cnt++;
            if (end_k == 0) end_k = k;
         end
         if (k == 1) pn_k1 = int'(o[0]);
         if (k == 2) pn_k2 = int'(o[0]);
         if (reset_at != 0 && k == reset_at + 1) begin
            zero_ok = (o == 7'b0) ? 1 : 0;
            reset = 1'b0;
         end
         if (reset_at != 0 && k == reset_at) reset = 1'b1;
         if (toggle_at != 0 && k == toggle_at) set_start(sel, 1'b0);
         if (toggle_at != 0 && k == toggle_at + 1) set_start(sel, 1'b1);
      end
      set_start(sel, 1'b0);
      tick();
   endtask

   int rk, rc, lc, mc, rn, ek, ec, p1, p2, zo;
   int seen;

   initial begin
      reset = 1'b1; start_a = 1'b1; start_b = 1'b1; sig = 16'hBEEF;
      repeat (3) tick();
      check("reset_outputs_a", int'(obs(1'b0)), 0);
      check("reset_outputs_b", int'(obs(1'b1)), 0);

      // Start held high through reset release: no session.
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (running_a || lfsr_rst_a || bist_end_a) seen++;
      end
      check("held_start_no_session", seen, 0);
      start_a = 1'b0; start_b = 1'b0;
      tick();

      // Passing session.
      session(1'b0, 15, 0, 0, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("pass_init_cycle", rk, 1);
      check("pass_init_count", rc, 1);
      check("pass_lfsr_en_cycles", lc, 8);
      check("pass_misr_en_cycles", mc, 9);
      check("pass_running_cycles", rn, 11);
      check("pass_end_cycle", ek, 12);
      check("pass_end_count", ec, 1);
      check("pass_verdict", int'(pass_a), 1);

      // Failing signature: verdict held until next INIT, then cleared.
      sig = 16'hBEEE;
      session(1'b0, 15, 0, 0, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("fail_held_at_init", p1, 1);
      check("fail_cleared_after_init", p2, 0);
      check("fail_end_cycle", ek, 12);
      check("fail_end_count", ec, 1);
      check("fail_verdict", int'(pass_a), 0);

      // Second start edge during RUN is ignored.
      sig = 16'hBEEF;
      session(1'b0, 15, 4, 0, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("retrig_init_count", rc, 1);
      check("retrig_lfsr_en_cycles", lc, 8);
      check("retrig_end_cycle", ek, 12);
      check("retrig_end_count", ec, 1);
      check("retrig_verdict", int'(pass_a), 1);

      // Reset in the middle of RUN.
      session(1'b0, 15, 0, 5, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("midreset_all_zero", zo, 1);
      check("midreset_no_end", ec, 0);
      check("midreset_verdict", int'(pass_a), 0);
      session(1'b0, 15, 0, 0, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("after_reset_end_cycle", ek, 12);
      check("after_reset_misr_cycles", mc, 9);
      check("after_reset_verdict", int'(pass_a), 1);

      // PIPE_LAT=0 build: no flush phase.
      session(1'b1, 15, 0, 0, rk, rc, lc, mc, rn, ek, ec, p1, p2, zo);
      check("nolat_init_cycle", rk, 1);
      check("nolat_lfsr_en_cycles", lc, 8);
      check("nolat_misr_en_cycles", mc, 8);
      check("nolat_running_cycles", rn, 10);
      check("nolat_end_cycle", ek, 11);
      check("nolat_end_count", ec, 1);
      check("nolat_verdict", int'(pass_b), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
